// File: rtl/ram_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_slot_sequencer
// Purpose  : Time-division sequencer for one synchronous RAM port. A clock
//            enable is divided down from clk, every frame is cut into NCH
//            slots of SLOT_LEN enables, and the requester that owns the
//            current slot gets one RAM access. Read data is latched per
//            channel and every access is acknowledged with a one-clk pulse.
//
// Ports    : clk         system clock
//            reset       synchronous, active-high
//            ena         one-clk clock-enable pulse every DIV clks
//            slot        index of the slot currently in progress
//            frame_start pulse on the enable that opens slot 0, phase 0
//            req/we      per-channel request level and write flag
//            addr/wdata  packed per-channel address and write data
//            ack         one-clk completion pulse per channel
//            rdata       packed per-channel read data, held between reads
//            mem_addr    RAM address
//            mem_we      RAM write strobe
//            mem_wdata   RAM write data
//            mem_q       RAM read data, one clk after mem_addr
//
// Options  : CPU_SLOT_STEAL_EN - when defined, an idle slot k != 0 is handed
//            to channel 0 if channel 0 is requesting. Default: strict TDM.
//
// Revision : 1.0 - initial release
// ============================================================================
module ram_slot_sequencer #(
    parameter  int DIV      = 4,
    parameter  int SLOT_LEN = 4,
    parameter  int NCH      = 2,
    parameter  int ADDR_W   = 16,
    parameter  int DATA_W   = 8,
    localparam int c_SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ena,
    output logic [c_SW-1:0]       slot,
    output logic                  frame_start,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        ack,
    output logic [NCH*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_q
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CW = (DIV > 1)      ? $clog2(DIV)      : 1;
    localparam int c_PW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DIV - 1);
    localparam logic [c_PW-1:0] c_PH_LAST   = c_PW'(SLOT_LEN - 1);
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(NCH - 1);

    // ------------------------------------------------------------------------
    // Timing chain: divider -> phase -> slot
    // ------------------------------------------------------------------------
    logic [c_CW-1:0] r_cnt;
    logic            r_ena;
    logic [c_PW-1:0] r_ph;
    logic [c_SW-1:0] r_slot;

    // ------------------------------------------------------------------------
    // Access state
    // ------------------------------------------------------------------------
    logic              r_granted;
    logic [c_SW-1:0]   r_gch;
    logic              r_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [NCH-1:0]    r_ack;
    logic [DATA_W-1:0] r_rdata [NCH];

    // Per-channel views of the packed request buses
    logic [ADDR_W-1:0] w_addr_ch  [NCH];
    logic [DATA_W-1:0] w_wdata_ch [NCH];

    logic              w_grant;
    logic [c_SW-1:0]   w_sel;
    logic              w_complete;

    // ------------------------------------------------------------------------
    // Bus unpacking / packing
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign w_addr_ch[gi]                  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_ch[gi]                 = wdata[gi*DATA_W +: DATA_W];
            assign rdata[gi*DATA_W +: DATA_W]     = r_rdata[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Divider, phase and slot counters.
    // ena is registered from the divider terminal count, so with the counter
    // cleared by reset the first pulse lands exactly DIV clks after release
    // (and at DIV=1 the enable is high on every clk after release).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_ena  <= 1'b0;
            r_ph   <= '0;
            r_slot <= '0;
        end else begin
            r_ena <= (r_cnt == c_CNT_LAST);
            r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;

            if (r_ena) begin
                if (r_ph == c_PH_LAST) begin
                    r_ph   <= '0;
                    r_slot <= (r_slot == c_SLOT_LAST) ? '0 : r_slot + 1'b1;
                end else begin
                    r_ph <= r_ph + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant decision: only evaluated on the enable that opens a slot.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant = 1'b0;
        w_sel   = r_slot;
        if (r_ena && (r_ph == '0)) begin
            if (req[r_slot]) begin
                w_grant = 1'b1;
            end
`ifdef CPU_SLOT_STEAL_EN
            // Owner is idle: hand the slot to channel 0 unless it already
            // has an access outstanding.
            else if ((r_slot != '0) && req[0] && !(r_granted && (r_gch == '0))) begin
                w_grant = 1'b1;
                w_sel   = '0;
            end
`endif
        end
    end

    // Completion on the last enable of the slot. By then mem_addr has been
    // stable for (SLOT_LEN-1)*DIV clks, so mem_q is valid for the access.
    assign w_complete = r_ena && (r_ph == c_PH_LAST) && r_granted;

    // ------------------------------------------------------------------------
    // Access sequencing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_granted   <= 1'b0;
            r_gch       <= '0;
            r_wr        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_ack       <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            // Strobes are single-clk by default
            r_mem_we <= 1'b0;
            r_ack    <= '0;

            if (w_complete) begin
                r_ack[r_gch] <= 1'b1;
                r_granted    <= 1'b0;
                if (!r_wr) begin
                    r_rdata[r_gch] <= mem_q;
                end
            end

            // Address/data are only loaded on a grant, so an idle slot
            // leaves the RAM-side bus exactly as the last access left it.
            if (w_grant) begin
                r_granted   <= 1'b1;
                r_gch       <= w_sel;
                r_wr        <= we[w_sel];
                r_mem_we    <= we[w_sel];
                r_mem_addr  <= w_addr_ch[w_sel];
                r_mem_wdata <= w_wdata_ch[w_sel];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ena         = r_ena;
    assign slot        = r_slot;
    assign frame_start = r_ena && (r_ph == '0) && (r_slot == '0);
    assign ack         = r_ack;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_slot_sequencer
// Purpose  : Self-checking bench for ram_slot_sequencer (DIV=4, SLOT_LEN=4,
//            NCH=2). Directed timing sequences, a table of single accesses,
//            a back-to-back channel-0 sequence and a randomized run checked
//            against a timeline model derived from the frame arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_slot_sequencer;

    localparam int DIV      = 4;
    localparam int SLOT_LEN = 4;
    localparam int NCH      = 2;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int LAT      = (SLOT_LEN - 1) * DIV + 1;
    localparam int FRAME    = NCH * SLOT_LEN * DIV;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ena;
    logic [0:0]            slot;
    logic                  frame_start;
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*ADDR_W-1:0] addr;
    logic [NCH*DATA_W-1:0] wdata;
    logic [NCH-1:0]        ack;
    logic [NCH*DATA_W-1:0] rdata;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_q;

    always #5 clk = ~clk;

    ram_slot_sequencer #(
        .DIV      (DIV),
        .SLOT_LEN (SLOT_LEN),
        .NCH      (NCH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .slot        (slot),
        .frame_start (frame_start),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_q       (mem_q)
    );

    // Synchronous RAM with a preload port for the bench
    bit [7:0]  ram [65536];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    always @(posedge clk) begin
        if (pl_en)       ram[pl_addr]  <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    // Clk count since reset release: value k is seen just after edge k
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic set_ch(input int ch, input bit r, input bit w,
                          input logic [15:0] a, input logic [7:0] d);
        req[ch]             = r;
        we[ch]              = w;
        addr[ch*16 +: 16]   = a;
        wdata[ch*8 +: 8]    = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ena"},   ena, 0);
        chk({tag, "_slot"},  slot, 0);
        chk({tag, "_fs"},    frame_start, 0);
        chk({tag, "_ack"},   ack, 0);
        chk({tag, "_we"},    mem_we, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Timeline model: position of clk t inside the frame
    function automatic bit m_ena(input int t);
        return (t > 0) && ((t % DIV) == 0);
    endfunction
    function automatic int m_ph(input int t);
        return (t < 1) ? 0 : ((t - 1) / DIV) % SLOT_LEN;
    endfunction
    function automatic int m_slot(input int t);
        return (t < 1) ? 0 : (((t - 1) / DIV) / SLOT_LEN) % NCH;
    endfunction

    typedef struct {
        int          ch;
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_rd [NCH];
        int         t;
        bit         got;
        int         ack_t [3];
        int         n_ack;
        int         wait_rearm;
        // random-run model state
        bit          pv;
        int          pch, gcyc;
        bit          pwe;
        logic [15:0] paddr;
        logic [7:0]  pwdata, prd;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic [7:0]  e_rd [NCH];
        logic [7:0]  ref_mem [16];
        logic [NCH-1:0] exp_ack;
        bit          exp_we;
        int          g, s;

        tbl[0]  = '{0, 1'b1, 16'h0010, 8'h11, 8'h00};
        tbl[1]  = '{1, 1'b1, 16'h0020, 8'h22, 8'h00};
        tbl[2]  = '{0, 1'b0, 16'h0020, 8'hE7, 8'h22};
        tbl[3]  = '{1, 1'b0, 16'h0010, 8'h9B, 8'h11};
        tbl[4]  = '{1, 1'b0, 16'h1C00, 8'h01, 8'h3C};
        tbl[5]  = '{0, 1'b1, 16'hFFFF, 8'hFF, 8'h00};
        tbl[6]  = '{1, 1'b0, 16'hFFFF, 8'h44, 8'hFF};
        tbl[7]  = '{1, 1'b0, 16'h0000, 8'h66, 8'h00};
        tbl[8]  = '{0, 1'b0, 16'h0400, 8'h77, 8'hA5};
        tbl[9]  = '{0, 1'b1, 16'h0000, 8'h5A, 8'h00};
        tbl[10] = '{0, 1'b0, 16'h0000, 8'h88, 8'h5A};

        req = '0; we = '0; addr = '0; wdata = '0;

        // ---------------- Divider, write ch0, read ch1 ----------------
        do_reset(2);
        preload(16'h1C00, 8'h3C);
        chk_reset_state("rst0");
        set_ch(0, 1'b1, 1'b1, 16'h0400, 8'hA5);
        set_ch(1, 1'b1, 1'b0, 16'h1C00, 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            t = cyc;
            chk("ena", ena, (t % 4) == 0);
            chk("frame_start", frame_start, (t == 4) || (t == 36));
            chk("slot", slot, (t >= 17) && (t <= 32));
            chk("mem_we", mem_we, t == 5);
            chk("ack", ack, (t == 17) ? 2'b01 : (t == 33) ? 2'b10 : 2'b00);
            if (t == 5)  chk("wr_addr", mem_addr, 16'h0400);
            if (t == 5)  chk("wr_data", mem_wdata, 8'hA5);
            if (t == 21) chk("rd_addr", mem_addr, 16'h1C00);
            if (t == 33) chk("rd_rdata", rdata, 16'h3C00);
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
        end
        chk("ram_0400", ram[16'h0400], 8'hA5);

        // ---------------- Reset in the middle of a ch1 access ----------------
        set_ch(1, 1'b1, 1'b0, 16'h0400, 8'h00);
        for (int k = 0; k < 20 && cyc != 52; k++) begin
            tick();
            chk("pre_rst_ack", ack, 0);
        end
        tick();
        chk("mid_grant_addr", mem_addr, 16'h0400);
        reset = 1'b1;
        tick();
        chk_reset_state("rst1");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            t = cyc;
            chk("rr_ack", ack, (t == 33) ? 2'b10 : 2'b00);
            if (t == 21) chk("rr_addr", mem_addr, 16'h0400);
            if (t == 32) chk("rr_rdata_pre", rdata, 16'h0000);
            if (t == 33) chk("rr_rdata", rdata, 16'hA500);
            if (ack[1]) req[1] = 1'b0;
        end

        // ---------------- Table of single accesses ----------------
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'hA5;
        foreach (tbl[i]) begin
            set_ch(tbl[i].ch, 1'b1, tbl[i].wr, tbl[i].a, tbl[i].d);
            got = 1'b0;
            for (int k = 0; k < FRAME + LAT + 4 && !got; k++) begin
                tick();
                if (ack[1 - tbl[i].ch]) chk("tbl_other_ack", ack, 2'b1 << tbl[i].ch);
                if (ack[tbl[i].ch]) got = 1'b1;
            end
            chk($sformatf("tbl%0d_acked", i), got, 1'b1);
            req[tbl[i].ch] = 1'b0;
            if (!tbl[i].wr) exp_rd[tbl[i].ch] = tbl[i].exp_rd;
            chk($sformatf("tbl%0d_rdata", i), rdata, {exp_rd[1], exp_rd[0]});
            if (tbl[i].wr) chk($sformatf("tbl%0d_ram", i), ram[tbl[i].a], tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_ack_single", i), ack, 0);
        end

        // ---------------- Channel 0 back-to-back reads ----------------
        do_reset(2);
        set_ch(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        reset = 1'b0;
        n_ack = 0;
        wait_rearm = 0;
        for (int k = 0; k < 200 && n_ack < 3; k++) begin
            tick();
            if (wait_rearm) begin
                req[0] = 1'b1;
                wait_rearm = 0;
            end
            if (ack[0]) begin
                ack_t[n_ack] = cyc;
                n_ack++;
                req[0] = 1'b0;
                wait_rearm = 1;
            end
        end
        chk("b2b_count", n_ack, 3);
        chk("b2b_first", ack_t[0], 17);
`ifdef CPU_SLOT_STEAL_EN
        chk("b2b_gap1", ack_t[1] - ack_t[0], 16);
        chk("b2b_gap2", ack_t[2] - ack_t[1], 16);
`else
        chk("b2b_gap1", ack_t[1] - ack_t[0], 32);
        chk("b2b_gap2", ack_t[2] - ack_t[1], 32);
`endif
        chk("b2b_rdata", rdata[7:0], 8'h11);

        // ---------------- Randomized run against the timeline model ----------
        req = '0;
        do_reset(2);
        reset = 1'b0;
        pv = 1'b0; pch = 0; gcyc = 0; pwe = 1'b0;
        paddr = '0; pwdata = '0; prd = '0;
        e_addr = '0; e_wdata = '0;
        for (int i = 0; i < NCH; i++) e_rd[i] = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int k = 0; k < 1500; k++) begin
            tick();
            t = cyc;
            exp_we = pv && (t == gcyc + 1) && pwe;
            if (pv && (t == gcyc + 1)) begin
                e_addr  = paddr;
                e_wdata = pwdata;
            end
            exp_ack = '0;
            if (pv && (t == gcyc + LAT)) begin
                exp_ack[pch] = 1'b1;
                if (!pwe) e_rd[pch] = prd;
                pv = 1'b0;
            end
            chk("r_ena", ena, m_ena(t));
            chk("r_fs", frame_start, m_ena(t) && m_ph(t) == 0 && m_slot(t) == 0);
            chk("r_slot", slot, m_slot(t));
            chk("r_we", mem_we, exp_we);
            chk("r_addr", mem_addr, e_addr);
            chk("r_wdata", mem_wdata, e_wdata);
            chk("r_ack", ack, exp_ack);
            chk("r_rdata", rdata, {e_rd[1], e_rd[0]});

            for (int ch = 0; ch < NCH; ch++) begin
                if (ack[ch]) begin
                    req[ch] = 1'b0;
                end else if (req[ch] && pv && pch == ch && $urandom_range(0, 7) == 0) begin
                    req[ch] = 1'b0;
                end else if (!req[ch] && $urandom_range(0, 3) == 0) begin
                    set_ch(ch, 1'b1, 1'($urandom_range(0, 1)),
                           16'h2000 + 16'($urandom_range(0, 15)), 8'($urandom));
                end
            end

            if (m_ena(t) && m_ph(t) == 0) begin
                s = m_slot(t);
                g = -1;
                if (req[s]) g = s;
`ifdef CPU_SLOT_STEAL_EN
                else if (s != 0 && req[0] && !(pv && pch == 0)) g = 0;
`endif
                if (g >= 0) begin
                    pv     = 1'b1;
                    pch    = g;
                    gcyc   = t;
                    pwe    = we[g];
                    paddr  = addr[g*16 +: 16];
                    pwdata = wdata[g*8 +: 8];
                    if (pwe) ref_mem[paddr[3:0]] = pwdata;
                    else     prd = ref_mem[paddr[3:0]];
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("r_ram%0d", i), ram[16'h2000 + 16'(i)], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_slot_sequencer.md
Name: ram_slot_sequencer

Overview:
Parametrised time-division RAM sequencer. It replaces the ad-hoc clock-enable divider and RAS/CAS address/data latching at the top level.
- Derives a clock enable from the system clock.
- Divides each frame into NCH fixed slots.
- Grants one requester (CPU, VDG, DMA, …) per slot to a shared synchronous dual-port RAM port and latches the read data per channel.
- Sits between the bus masters and the dpram port-B side.

Parameters:
DIV, 4, system clocks per enable pulse (>=1; 1 = enable constantly high)
SLOT_LEN, 4, enable pulses per slot (>=2)
NCH, 2, number of channels/slots (>=1)
ADDR_W, 16, address width
DATA_W, 8, data width

Ports:
clk  in  1  system clock (57.272 MHz)
reset  in  1  synchronous, active-high
ena  out  1  clock-enable pulse, one clk wide
slot  out  SW  current slot index, SW = max(1,$clog2(NCH))
frame_start  out  1  one-clk pulse on the enable that starts slot 0, phase 0
req  in  NCH  per-channel request, level, held until ack
we  in  NCH  per-channel write (1) / read (0)
addr  in  NCH*ADDR_W  packed addresses, channel k at [k*ADDR_W +: ADDR_W]
wdata  in  NCH*DATA_W  packed write data
ack  out  NCH  one-clk completion pulse per channel
rdata  out  NCH*DATA_W  per-channel latched read data, held until next read completes
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write strobe
mem_wdata  out  DATA_W  RAM write data
mem_q  in  DATA_W  RAM read data, 1-clk synchronous latency

Behaviour:
- Divider: counter 0..DIV-1 advances every clk. ena=1 on the clk where counter==DIV-1 (registered). At DIV=1, ena=1 every clk after reset.
- Phase counter ph 0..SLOT_LEN-1 advances on ena. On wrap, slot advances 0..NCH-1 and wraps to 0. frame_start=ena & slot==0 & ph==0.
- Grant: on ena with ph==0, if req[slot]=1:
  - Set granted=1 and gch=slot.
  - Capture addr, we and wdata of that channel into mem_addr, the internal write flag and mem_wdata.
  - If req[slot]=0, granted=0; mem_addr/mem_wdata hold their previous values.
- Write: mem_we=1 for exactly the one clk following the grant ena, otherwise 0.
- Complete: on ena with ph==SLOT_LEN-1 and granted:
  - For reads, rdata[gch] <= mem_q.
  - ack[gch]=1 for the next clk only; granted cleared.
  - Writes ack the same way; rdata is unchanged.
- Latency from grant ena to ack: (SLOT_LEN-1)*DIV+1 clk. Worst-case wait for a slot: NCH*SLOT_LEN*DIV clk.
- req dropped mid-slot: the access still completes and acks. A req held after ack is re-granted in the channel's next slot (requester must drop req on ack to avoid a repeat).
- Ungranted slot: no mem_we, no ack, rdata unchanged.
- At most one ack bit set per clk.
- Reset (synchronous, any time): counter=0, ph=0, slot=0, ena=0, frame_start=0, granted=0, ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0. An in-flight access is abandoned with no ack. The first ena occurs DIV clks after reset deasserts.

Optional Feature:
CPU_SLOT_STEAL_EN.
- Defined: at ph==0 of slot k!=0, if req[k]=0, req[0]=1 and channel 0 has no access in flight, channel 0 is granted that slot. gch=0; ack[0] and rdata[0] follow the normal completion rule. The slot output still shows k.
- Undefined: strict TDM; idle slots are wasted.

Test Plan:
- Divider/reset: DIV=4, SLOT_LEN=4, NCH=2 → after reset release, ena pulses at clk 4,8,12…; frame_start at clk 4 and clk 36; slot toggles every 16 clk.
- Write: req[0]=1, we[0]=1, addr 0x0400, wdata 0xA5, raised before clk 4 → mem_addr=0x0400 and mem_we=1 for one clk after clk 4; ack[0] pulse 13 clk later; RAM model holds 0xA5.
- Read: RAM[0x1C00]=0x3C, req[1] read 0x1C00 → granted at slot-1 start (clk 20), rdata[1]=0x3C, ack[1] single pulse; rdata[0] unchanged.
- Idle/collision: req[0] and req[1] both asserted continuously, req dropped on ack → acks strictly alternate ch0, ch1 every 16 clk; mem_we never high in a slot whose owner has req=0.
- Reset mid-op: assert reset 2 clk after a ch1 grant → no ack[1], mem_we=0, all outputs zero next clk; after release, ch1 is re-served in its next slot.
- CPU_SLOT_STEAL_EN: req[1]=0, ch0 issues back-to-back reads → acks every 16 clk with the macro, every 32 clk without.
